ov5640_dvp_gen: RTL and testbench

Synthesizable OV5640 DVP source model: generates the 8-bit camera bus (vsync, href, data) that the camera capture path receives. Each pixel is sent as two bytes of RGB565, high byte first. Selectable test patterns let the capture/SDRAM path be brought up and regression-tested without a sensor. The block sits in place of the sensor pins and is clocked by the same clock the capture logic uses as pixel clock.

---
 rtl/ov5640_dvp_gen.sv | 150 +++++++++++++++
 tb/tb_ov5640_dvp_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ov5640_dvp_gen.sv
// OV5640 DVP source model: emits vsync/href/byte-serial RGB565 test patterns
// in place of the sensor, on the capture path's pixel clock.
module ov5640_dvp_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned VSYNC_LINES = 4,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_BACK      = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned LINE_PERIOD = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW          = $clog2(LINE_PERIOD);
  localparam int unsigned VM1         = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
  localparam int unsigned VM2         = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
  localparam int unsigned VMAX        = (VM1 > VM2) ? VM1 : VM2;
  localparam int unsigned VW          = $clog2(VMAX + 1);
  localparam int unsigned BAR_W       = H_ACTIVE / 8;
  localparam int unsigned BPW         = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_V_FRONT, S_ACTIVE, S_V_BACK
  } state_t;

  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [1:0]      pat;
  logic [2:0]      bar_idx;
  logic [BPW-1:0]  bar_px;

  int unsigned     lines_c;
  logic            line_last_c;
  logic            state_last_c;
  logic            href_c;
  logic [15:0]     px_x_c;
  logic [15:0]     px_y_c;
  logic [15:0]     pix_c;
  logic [7:0]      byte_c;

  // Line/state boundaries and the pixel for the current byte slot
  always_comb begin
    lines_c      = 1;
    line_last_c  = (h_cnt == HW'(LINE_PERIOD - 1));
    href_c       = (state == S_ACTIVE) && (h_cnt < HW'(2 * H_ACTIVE));
    px_x_c       = 16'(h_cnt >> 1);
    px_y_c       = 16'(v_cnt);
    pix_c        = 16'h0000;
    byte_c       = 8'h00;
    case (state)
      S_VSYNC:   lines_c = VSYNC_LINES;
      S_V_FRONT: lines_c = V_FRONT;
      S_ACTIVE:  lines_c = V_ACTIVE;
      S_V_BACK:  lines_c = V_BACK;
      default:   lines_c = 1;
    endcase
    state_last_c = line_last_c && (v_cnt == VW'(lines_c - 1));
    case (pat)
      2'd0: begin
        case (bar_idx)
          3'd0:    pix_c = 16'hFFFF;
          3'd1:    pix_c = 16'hFFE0;
          3'd2:    pix_c = 16'h07FF;
          3'd3:    pix_c = 16'h07E0;
          3'd4:    pix_c = 16'hF81F;
          3'd5:    pix_c = 16'hF800;
          3'd6:    pix_c = 16'h001F;
          default: pix_c = 16'h0000;
        endcase
      end
      2'd1:    pix_c = px_x_c;
      2'd2:    pix_c = frame_cnt;
      default: pix_c = (((px_x_c ^ px_y_c) & 16'h0008) != 16'h0000) ? 16'hFFFF : 16'h0000;
    endcase
    if (href_c) byte_c = h_cnt[0] ? pix_c[7:0] : pix_c[15:8];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      pat       <= 2'd0;
      bar_idx   <= 3'd0;
      bar_px    <= '0;
      frame_cnt <= 16'h0000;
      dvp_vsync <= 1'b0;
      dvp_href  <= 1'b0;
      dvp_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
        if (gen_en) begin
          state <= S_VSYNC;
          pat   <= pattern_sel;
        end
      end else begin
        h_cnt <= line_last_c ? '0 : h_cnt + HW'(1);
        if (line_last_c) v_cnt <= state_last_c ? '0 : v_cnt + VW'(1);
        if (state_last_c) begin
          case (state)
            S_VSYNC:   state <= S_V_FRONT;
            S_V_FRONT: state <= S_ACTIVE;
            S_ACTIVE:  state <= S_V_BACK;
            default: begin
              frame_cnt <= frame_cnt + 16'd1;
              if (gen_en) begin
                state <= S_VSYNC;
                pat   <= pattern_sel;
              end else begin
                state <= S_IDLE;
              end
            end
          endcase
        end
      end

      // Bar position advances once per pixel, restarting at every line start
      if (state != S_ACTIVE || line_last_c) begin
        bar_idx <= 3'd0;
        bar_px  <= '0;
      end else if (href_c && h_cnt[0]) begin
        if (bar_px == BPW'(BAR_W - 1)) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px  <= bar_px + BPW'(1);
        end
      end

      dvp_vsync <= (state == S_VSYNC);
      dvp_href  <= href_c;
      dvp_data  <= byte_c;
      busy      <= (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_gen.sv
// Directed bench for ov5640_dvp_gen using the small 8x4 frame geometry.
module tb_ov5640_dvp_gen;

  localparam int FR = 140;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        gen_en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic [15:0] frame_cnt;
  logic        busy;

  ov5640_dvp_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
    .VSYNC_LINES(1), .V_FRONT(1), .V_BACK(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gen_en(gen_en),
    .pattern_sel(pattern_sel), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_data(dvp_data), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]   pat;
    logic [127:0] line;
    string        nm;
  } vec_t;

  vec_t       tbl[3];
  int         total = 0;
  int         bad = 0;
  int         ncyc;
  logic       vs_a[1024];
  logic       hr_a[1024];
  logic [7:0] d_a[1024];

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Start generation, record every busy cycle, optionally change inputs mid-run
  task automatic run_watch(input logic [1:0] p0, input int pat_at,
                           input logic [1:0] p1, input int off_at);
    ncyc = 0;
    pattern_sel = p0;
    gen_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (busy) begin
        if (ncyc < 1024) begin
          vs_a[ncyc] = dvp_vsync;
          hr_a[ncyc] = dvp_href;
          d_a[ncyc]  = dvp_data;
        end
        ncyc++;
      end else if (ncyc > 0) begin
        break;
      end
      if (ncyc == off_at) gen_en = 1'b0;
      if (ncyc == pat_at) pattern_sel = p1;
    end
    gen_en = 1'b0;
    chk("watch_timeout", int'(busy), 0);
  endtask

  // Compare one recorded frame against the expected line timing and bytes
  task automatic check_frame(input int f, input logic [127:0] line, input string nm);
    int vm = 0;
    int hm = 0;
    int dm = 0;
    for (int off = 0; off < FR; off++) begin
      int   idx = f * FR + off;
      logic ev = (off < 20);
      logic eh = (off >= 40) && (off < 120) && (((off - 40) % 20) < 16);
      logic [7:0] ed = 8'h00;
      if (eh) ed = line[127 - 8 * ((off - 40) % 20) -: 8];
      if (idx < 1024) begin
        if (vs_a[idx] !== ev) vm++;
        if (hr_a[idx] !== eh) hm++;
        if (d_a[idx] !== ed) dm++;
      end
    end
    chk({nm, "_vsync_errs"}, vm, 0);
    chk({nm, "_href_errs"}, hm, 0);
    chk({nm, "_data_errs"}, dm, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'd0, 128'hFFFFFFE007FF07E0F81FF800001F0000, "bars"};
    tbl[1] = '{2'd1, 128'h00000001000200030004000500060007, "ramp"};
    tbl[2] = '{2'd3, 128'h00000000000000000000000000000000, "checker"};

    repeat (2) @(negedge sys_clk);
    chk("reset_outputs", int'({dvp_vsync, dvp_href, dvp_data, busy, frame_cnt}), 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("idle_no_gen_en", int'({busy, dvp_vsync}), 0);

    // Single frames from a one-cycle gen_en pulse
    for (int i = 0; i < 3; i++) begin
      run_watch(tbl[i].pat, -1, 2'd0, 0);
      chk({tbl[i].nm, "_busy_len"}, ncyc, FR);
      check_frame(0, tbl[i].line, tbl[i].nm);
      chk({tbl[i].nm, "_frame_cnt"}, int'(frame_cnt), i + 1);
      repeat (3) @(negedge sys_clk);
    end

    // Back-to-back solid frames, pattern change mid-frame, gen_en drop mid-ACTIVE
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    run_watch(2'd2, 2 * FR + 60, 2'd1, 3 * FR + 70);
    chk("b2b_busy_len", ncyc, 4 * FR);
    check_frame(0, {8{16'h0000}}, "solid0");
    check_frame(1, {8{16'h0001}}, "solid1");
    check_frame(2, {8{16'h0002}}, "solid2");
    check_frame(3, tbl[1].line, "ramp_after_toggle");
    chk("b2b_frame_cnt", int'(frame_cnt), 4);

    // Asynchronous reset in the middle of an href pulse
    gen_en = 1'b1;
    @(negedge sys_clk);
    gen_en = 1'b0;
    begin
      int w = 0;
      while (!dvp_href && w < 200) begin
        @(negedge sys_clk);
        w++;
      end
      chk("href_seen", int'(dvp_href), 1);
    end
    #2 sys_rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({dvp_vsync, dvp_href, dvp_data, busy, frame_cnt}), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (30) @(negedge sys_clk);
    chk("post_reset_idle", int'({busy, dvp_vsync, dvp_href}), 0);

    // frame_cnt wrap from a preloaded value
    force dut.frame_cnt = 16'hFFFE;
    @(negedge sys_clk);
    release dut.frame_cnt;
    @(negedge sys_clk);
    chk("preload_frame_cnt", int'(frame_cnt), 16'hFFFE);
    run_watch(2'd2, -1, 2'd0, FR + 10);
    chk("wrap_busy_len", ncyc, 2 * FR);
    check_frame(0, {8{16'hFFFE}}, "solid_fffe");
    check_frame(1, {8{16'hFFFF}}, "solid_ffff");
    chk("wrap_frame_cnt", int'(frame_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
